// File: rtl/ser_word_aligner.sv
// Receive-side word aligner for one serial lane: hunts for the synch pattern in an
// MSB-first bitstream, confirms word boundaries, then forwards aligned words and status.
module ser_word_aligner #(
  parameter int WORD_W   = 32,
  parameter int LOCK_CNT = 4,
  parameter int MISS_MAX = 3,
  parameter int ERR_W    = 8
) (
  input  logic              clock,
  input  logic              rst,
  input  logic              serial_in,
  input  logic              synch_mode,
  input  logic [WORD_W-1:0] synch_pattern,
  output logic [WORD_W-1:0] word_out,
  output logic              word_valid,
  output logic              locked,
  output logic [4:0]        phase,
  output logic              lock_lost,
  output logic [ERR_W-1:0]  err_count
);

  typedef enum logic [1:0] {
    HUNT    = 2'd0,
    CONFIRM = 2'd1,
    LOCKED  = 2'd2
  } state_t;

  localparam logic [ERR_W-1:0] ERR_MAX = {ERR_W{1'b1}};
  localparam logic [ERR_W-1:0] ERR_ONE = {{(ERR_W-1){1'b0}}, 1'b1};
  localparam logic [3:0]       LOCK_TH = 4'(LOCK_CNT);
  localparam logic [3:0]       MISS_TH = 4'(MISS_MAX);

  state_t            state;
  logic [WORD_W-1:0] sr;
  logic [4:0]        bit_cnt;
  logic [4:0]        free_cnt;
  logic [5:0]        fill_cnt;
  logic [3:0]        conf;
  logic [3:0]        miss;

  logic       match;
  logic       boundary;
  logic [3:0] conf_next;
  logic [3:0] miss_next;

  // A freshly reset shift register must never match an all-zero pattern.
  assign match     = (fill_cnt == 6'd32) && (sr == synch_pattern);
  assign boundary  = (bit_cnt == 5'd31);
  assign conf_next = conf + 4'd1;
  assign miss_next = miss + 4'd1;

  // Shift register, counters, alignment FSM and all registered outputs.
  always_ff @(posedge clock) begin
    if (rst) begin
      state      <= HUNT;
      sr         <= '0;
      bit_cnt    <= 5'd0;
      free_cnt   <= 5'd0;
      fill_cnt   <= 6'd0;
      conf       <= 4'd0;
      miss       <= 4'd0;
      word_out   <= '0;
      word_valid <= 1'b0;
      locked     <= 1'b0;
      phase      <= 5'd0;
      lock_lost  <= 1'b0;
      err_count  <= '0;
    end else begin
      sr         <= {sr[WORD_W-2:0], serial_in};
      free_cnt   <= free_cnt + 5'd1;
      bit_cnt    <= bit_cnt + 5'd1;
      word_valid <= 1'b0;
      lock_lost  <= 1'b0;
      if (fill_cnt != 6'd32) begin
        fill_cnt <= fill_cnt + 6'd1;
      end

      case (state)
        HUNT: begin
          if (match) begin
            bit_cnt <= 5'd0;
            phase   <= free_cnt;
            conf    <= 4'd1;
            miss    <= 4'd0;
            if (LOCK_CNT == 1) begin
              state  <= LOCKED;
              locked <= 1'b1;
            end else begin
              state <= CONFIRM;
            end
          end
        end

        CONFIRM: begin
          if (boundary) begin
            if (match) begin
              conf <= conf_next;
              if (conf_next >= LOCK_TH) begin
                state  <= LOCKED;
                locked <= 1'b1;
                miss   <= 4'd0;
              end
            end else begin
              state <= HUNT;
            end
          end
        end

        LOCKED: begin
          if (boundary) begin
            // The word at a lock-dropping boundary is still forwarded.
            word_out   <= sr;
            word_valid <= 1'b1;
            if (synch_mode) begin
              if (!match) begin
                miss <= miss_next;
                if (err_count != ERR_MAX) begin
                  err_count <= err_count + ERR_ONE;
                end
                if (miss_next >= MISS_TH) begin
                  state     <= HUNT;
                  locked    <= 1'b0;
                  lock_lost <= 1'b1;
                end
              end else begin
                miss <= 4'd0;
              end
            end
          end
        end

        default: begin
          state  <= HUNT;
          locked <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ser_word_aligner.sv
// Self-checking bench for ser_word_aligner: directed table, hand-written corner
// sequences and a randomized stream, all compared against a cycle-level reference model.
module tb_ser_word_aligner;

  localparam int          LOCK_CNT = 4;
  localparam int          MISS_MAX = 3;
  localparam logic [31:0] P        = 32'h5A5A_F00F;
  localparam logic [31:0] NP       = ~P;

  logic        clock = 1'b0;
  logic        rst;
  logic        serial_in;
  logic        synch_mode;
  logic [31:0] synch_pattern;
  logic [31:0] word_out;
  logic        word_valid;
  logic        locked;
  logic [4:0]  phase;
  logic        lock_lost;
  logic [7:0]  err_count;

  ser_word_aligner #(.WORD_W(32), .LOCK_CNT(LOCK_CNT), .MISS_MAX(MISS_MAX), .ERR_W(8)) dut (
    .clock        (clock),
    .rst          (rst),
    .serial_in    (serial_in),
    .synch_mode   (synch_mode),
    .synch_pattern(synch_pattern),
    .word_out     (word_out),
    .word_valid   (word_valid),
    .locked       (locked),
    .phase        (phase),
    .lock_lost    (lock_lost),
    .err_count    (err_count)
  );

  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: bit history plus the time (edge index) of the next expected boundary.
  int          m_n, m_fill, m_state, m_next, m_conf, m_miss, m_err, m_phase;
  logic [31:0] m_last, m_word;
  logic        m_valid, m_locked, m_lost;

  function automatic void model_reset();
    m_n = 0; m_fill = 0; m_state = 0; m_next = 0; m_conf = 0; m_miss = 0;
    m_err = 0; m_phase = 0; m_last = '0; m_word = '0;
    m_valid = 1'b0; m_locked = 1'b0; m_lost = 1'b0;
  endfunction

  function automatic void model_step(logic b, logic sm, logic [31:0] pat);
    bit hit;
    hit = (m_fill >= 32) && (m_last == pat);
    m_valid = 1'b0;
    m_lost  = 1'b0;
    if (m_state == 0) begin
      if (hit) begin
        m_next  = m_n + 32;
        m_conf  = 1;
        m_miss  = 0;
        m_phase = m_n % 32;
        m_state = (LOCK_CNT == 1) ? 2 : 1;
      end
    end else if (m_n == m_next) begin
      m_next = m_n + 32;
      if (m_state == 1) begin
        if (hit) begin
          m_conf = m_conf + 1;
          if (m_conf >= LOCK_CNT) begin
            m_state = 2;
            m_miss  = 0;
          end
        end else begin
          m_state = 0;
        end
      end else begin
        m_word  = m_last;
        m_valid = 1'b1;
        if (sm && !hit) begin
          m_miss = m_miss + 1;
          m_err  = (m_err < 255) ? m_err + 1 : 255;
          if (m_miss >= MISS_MAX) begin
            m_lost  = 1'b1;
            m_state = 0;
          end
        end else if (sm) begin
          m_miss = 0;
        end
      end
    end
    m_locked = (m_state == 2);
    m_last   = {m_last[30:0], b};
    m_fill   = m_fill + 1;
    m_n      = m_n + 1;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_model(input string name);
    check(name, {word_out, word_valid, locked, phase, lock_lost, err_count},
          {m_word, m_valid, m_locked, 5'(m_phase), m_lost, 8'(m_err)});
  endtask

  task automatic step(input logic b);
    serial_in = b;
    @(posedge clock);
    model_step(b, synch_mode, synch_pattern);
    #1;
    check_model("cycle");
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    serial_in = 1'b0;
    @(posedge clock);
    model_reset();
    #1;
    check_model("reset");
    check("reset outputs zero", {word_out, word_valid, locked, phase, lock_lost, err_count}, 64'd0);
    rst = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int b = 31; b >= 0; b--) step(w[b]);
  endtask

  typedef struct {
    logic [31:0] word;
    logic        sm;
    int          count;
    logic [31:0] exp_word;
    logic        exp_valid;
    logic        exp_locked;
    logic        exp_lost;
    logic [7:0]  exp_err;
  } vec_t;

  vec_t tbl[6];

  // Entry outcomes are observed one edge after the entry's last bit, at its final boundary.
  task automatic check_entry(input int k);
    check($sformatf("e%0d word_out", k),   word_out,   tbl[k].exp_word);
    check($sformatf("e%0d word_valid", k), word_valid, tbl[k].exp_valid);
    check($sformatf("e%0d locked", k),     locked,     tbl[k].exp_locked);
    check($sformatf("e%0d lock_lost", k),  lock_lost,  tbl[k].exp_lost);
    check($sformatf("e%0d err_count", k),  err_count,  tbl[k].exp_err);
  endtask

  initial begin
    logic [31:0] w;
    int          pre;

    rst = 1'b1; serial_in = 1'b0; synch_mode = 1'b1; synch_pattern = P;

    tbl[0] = '{P,            1'b1, 6, P,            1'b1, 1'b1, 1'b0, 8'd0};
    tbl[1] = '{NP,           1'b1, 3, NP,           1'b1, 1'b0, 1'b1, 8'd3};
    tbl[2] = '{P,            1'b1, 4, NP,           1'b0, 1'b1, 1'b0, 8'd3};
    tbl[3] = '{32'h0000_0001, 1'b0, 1, 32'h0000_0001, 1'b1, 1'b1, 1'b0, 8'd3};
    tbl[4] = '{32'hFFFF_FFFE, 1'b0, 1, 32'hFFFF_FFFE, 1'b1, 1'b1, 1'b0, 8'd3};
    tbl[5] = '{P,            1'b1, 2, P,            1'b1, 1'b1, 1'b0, 8'd3};

    // Directed table: lock, corrupt-and-relock, unchecked data words.
    do_reset();
    for (int i = 0; i < 6; i++) begin
      for (int wi = 0; wi < tbl[i].count; wi++) begin
        for (int b = 31; b >= 0; b--) begin
          step(tbl[i].word[b]);
          if (b == 31 && wi == 0 && i > 0) check_entry(i - 1);
          if (b == 30 && wi == 0) synch_mode = tbl[i].sm;
        end
      end
    end
    step(P[31]);
    check_entry(5);

    // 13-bit random prefix: match is seen one edge after the last pattern bit (edge 45).
    do_reset();
    synch_mode = 1'b1; synch_pattern = P;
    for (int i = 0; i < 13; i++) step(1'($urandom_range(0, 1)));
    for (int i = 0; i < 6; i++) send_word(P);
    check("prefix phase", phase, 5'd13);
    check("prefix locked", locked, 1'b1);
    check("prefix word", word_out, P);

    // All-zero pattern with zero input: no match until the shift register has filled.
    synch_pattern = 32'h0;
    do_reset();
    for (int i = 0; i < 128; i++) step(1'b0);
    check("zero pattern not yet locked", locked, 1'b0);
    step(1'b0);
    check("zero pattern locked", locked, 1'b1);
    check("zero pattern phase", phase, 5'd0);

    // Reset while locked: everything clears, no lock_lost pulse.
    do_reset();
    check("reset mid-lock lock_lost", lock_lost, 1'b0);
    step(1'b0);

    // Saturation: 150 x (bad, bad, good) keeps lock while producing 300 mismatches.
    synch_pattern = P; synch_mode = 1'b1;
    do_reset();
    for (int i = 0; i < 4; i++) send_word(P);
    for (int i = 0; i < 150; i++) begin
      send_word(NP);
      send_word(NP);
      send_word(P);
    end
    step(P[31]);
    check("err_count saturated", err_count, 8'd255);
    check("locked through saturation", locked, 1'b1);

    // Randomized stream against the model.
    synch_pattern = $urandom;
    synch_mode    = 1'b1;
    do_reset();
    pre = $urandom_range(0, 31);
    for (int i = 0; i < pre; i++) step(1'($urandom_range(0, 1)));
    for (int k = 0; k < 60; k++) begin
      case ($urandom_range(0, 9))
        0, 1:    w = $urandom;
        2:       w = synch_pattern ^ (32'h1 << $urandom_range(0, 31));
        default: w = synch_pattern;
      endcase
      for (int b = 31; b >= 0; b--) begin
        step(w[b]);
        if (b == 30) synch_mode = ($urandom_range(0, 7) != 0);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
